l1d_read_cache: RTL and testbench

//  Direct-mapped, read-only L1 data cache sitting directly downstream of the core/L1 address splitter.

---
 rtl/l1d_read_cache.sv | 211 +++++++++++++++++++++
 tb/tb_l1d_read_cache.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/l1d_read_cache.sv
// l1d_read_cache
//   Direct-mapped, read-only L1 data cache. A hit returns the addressed word
//   in the same cycle. A miss stalls the core while the whole 64-byte line is
//   refilled from L2 as 16 sequential 32-bit beats, then installs the line.
//   Because the cache is read-only, a conflict miss evicts the resident line
//   with no write-back.
//   Optional feature: define L1D_PERF_CNT_EN to add saturating hit_cnt and
//   miss_cnt outputs. The default build leaves the macro undefined.
module l1d_read_cache #(
    parameter int TAG_W    = 21,
    parameter int INDEX_W  = 5,
    parameter int OFFSET_W = 6
) (
    input  logic                clk,
    input  logic                nrst,
    input  logic [TAG_W-1:0]    tag_C_L1,
    input  logic [INDEX_W-1:0]  index_C_L1,
    input  logic [OFFSET_W-1:0] offset,
    input  logic                read_C_L1D,
    output logic                stall_L1D,
    output logic [31:0]         read_data_L1D_C,
    output logic                read_L1_L2,
    output logic [31:0]         address_L1_L2,
    input  logic                ready_L2_L1,
    input  logic [31:0]         read_data_L2_L1
`ifdef L1D_PERF_CNT_EN
    ,
    output logic [31:0]         hit_cnt,
    output logic [31:0]         miss_cnt
`endif
);

    localparam int NUM_SETS   = 2 ** INDEX_W;
    localparam int BEAT_W     = OFFSET_W - 2;
    localparam int LINE_WORDS = 2 ** BEAT_W;
    localparam logic [BEAT_W-1:0] LAST_BEAT = '1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REFILL = 2'd1,
        UPDATE = 2'd2
    } state_e;

    // Line storage. Only valid_q carries a reset value; stale tag/data
    // contents are harmless because valid_q gates every hit.
    logic [31:0]      data_mem [NUM_SETS][LINE_WORDS];
    logic [TAG_W-1:0] tag_mem  [NUM_SETS];

    state_e              state_q,      state_d;
    logic [BEAT_W-1:0]   beat_cnt_q,   beat_cnt_d;
    logic [TAG_W-1:0]    miss_tag_q,   miss_tag_d;
    logic [INDEX_W-1:0]  miss_index_q, miss_index_d;
    logic                read_l2_q,    read_l2_d;
    logic [31:0]         addr_l2_q,    addr_l2_d;
    logic [NUM_SETS-1:0] valid_q,      valid_d;

    logic                fill_we;
    logic                tag_we;
    logic                hit;
    logic                miss;
    logic [BEAT_W-1:0]   word_sel;
    logic [1:0]          unused_offset_bits;

    // Byte-within-word bits do not select anything in a word-wide read port.
    assign unused_offset_bits = offset[1:0];
    assign word_sel           = offset[OFFSET_W-1:2];

    // Lookup against the resident line of the requested set.
    always_comb begin
        hit  = read_C_L1D & valid_q[index_C_L1] & (tag_mem[index_C_L1] == tag_C_L1);
        miss = read_C_L1D & ~hit;
    end

    // Core-facing outputs: zero-latency hit data, stall on miss and for the
    // whole refill; everything forced low while reset is held.
    always_comb begin
        stall_L1D       = 1'b0;
        read_data_L1D_C = '0;
        if (!nrst) begin
            if (state_q == IDLE) begin
                stall_L1D = miss;
                if (hit) begin
                    read_data_L1D_C = data_mem[index_C_L1][word_sel];
                end
            end else begin
                stall_L1D = 1'b1;
            end
        end
    end

    assign read_L1_L2    = read_l2_q;
    assign address_L1_L2 = addr_l2_q;

    // Next-state logic for the IDLE -> REFILL -> UPDATE refill sequence.
    always_comb begin
        // NOTE: every variable gets a default first so no path through the
        // case statement leaves one unassigned and infers a latch.
        state_d      = state_q;
        beat_cnt_d   = beat_cnt_q;
        miss_tag_d   = miss_tag_q;
        miss_index_d = miss_index_q;
        read_l2_d    = read_l2_q;
        addr_l2_d    = addr_l2_q;
        valid_d      = valid_q;
        fill_we      = 1'b0;
        tag_we       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (miss) begin
                    miss_tag_d             = tag_C_L1;
                    miss_index_d           = index_C_L1;
                    // Invalidate first so a partially refilled line never hits.
                    valid_d[index_C_L1]    = 1'b0;
                    read_l2_d              = 1'b1;
                    addr_l2_d              = {tag_C_L1, index_C_L1, {OFFSET_W{1'b0}}};
                    state_d                = REFILL;
                end
            end
            REFILL: begin
                if (ready_L2_L1) begin
                    fill_we    = 1'b1;
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    if (beat_cnt_q == LAST_BEAT) begin
                        read_l2_d = 1'b0;
                        state_d   = UPDATE;
                    end
                end
            end
            UPDATE: begin
                tag_we                 = 1'b1;
                valid_d[miss_index_q]  = 1'b1;
                state_d                = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control state registers with synchronous reset; reset aborts a refill.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values, independent of statement order.
        if (nrst) begin
            state_q      <= IDLE;
            beat_cnt_q   <= '0;
            miss_tag_q   <= '0;
            miss_index_q <= '0;
            read_l2_q    <= 1'b0;
            addr_l2_q    <= '0;
            valid_q      <= '0;
        end else begin
            state_q      <= state_d;
            beat_cnt_q   <= beat_cnt_d;
            miss_tag_q   <= miss_tag_d;
            miss_index_q <= miss_index_d;
            read_l2_q    <= read_l2_d;
            addr_l2_q    <= addr_l2_d;
            valid_q      <= valid_d;
        end
    end

    // Tag and data array writes: one refill beat per accepted L2 beat, tag on UPDATE.
    always_ff @(posedge clk) begin
        // NOTE: the arrays are deliberately not reset; clearing them would
        // prevent RAM inference and valid_q already hides their contents.
        if (fill_we) begin
            data_mem[miss_index_q][beat_cnt_q] <= read_data_L2_L1;
        end
        if (tag_we) begin
            tag_mem[miss_index_q] <= miss_tag_q;
        end
    end

`ifdef L1D_PERF_CNT_EN
    logic [31:0] hit_cnt_q,  hit_cnt_d;
    logic [31:0] miss_cnt_q, miss_cnt_d;
    logic        replay_q,   replay_d;

    // Saturating counters; the replay hit right after UPDATE is part of the miss.
    always_comb begin
        replay_d   = (state_q == UPDATE);
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if ((state_q == IDLE) && hit && !replay_q && (hit_cnt_q != 32'hFFFF_FFFF)) begin
            hit_cnt_d = hit_cnt_q + 32'd1;
        end
        if ((state_q == IDLE) && miss && (miss_cnt_q != 32'hFFFF_FFFF)) begin
            miss_cnt_d = miss_cnt_q + 32'd1;
        end
    end

    // Performance counter registers.
    always_ff @(posedge clk) begin
        if (nrst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            replay_q   <= 1'b0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
            replay_q   <= replay_d;
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_l1d_read_cache.sv
// tb_l1d_read_cache
//   Directed scenarios plus randomized traffic against a reference model
//   that holds per-set valid/tag/line arrays and applies the cache rules
//   directly. Build with L1D_PERF_CNT_EN defined to also exercise counters.
module tb_l1d_read_cache;

    logic        clk;
    logic        nrst;
    logic [20:0] tag_C_L1;
    logic [4:0]  index_C_L1;
    logic [5:0]  offset;
    logic        read_C_L1D;
    logic        stall_L1D;
    logic [31:0] read_data_L1D_C;
    logic        read_L1_L2;
    logic [31:0] address_L1_L2;
    logic        ready_L2_L1;
    logic [31:0] read_data_L2_L1;
`ifdef L1D_PERF_CNT_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
`endif

    l1d_read_cache dut (
        .clk             (clk),
        .nrst            (nrst),
        .tag_C_L1        (tag_C_L1),
        .index_C_L1      (index_C_L1),
        .offset          (offset),
        .read_C_L1D      (read_C_L1D),
        .stall_L1D       (stall_L1D),
        .read_data_L1D_C (read_data_L1D_C),
        .read_L1_L2      (read_L1_L2),
        .address_L1_L2   (address_L1_L2),
        .ready_L2_L1     (ready_L2_L1),
        .read_data_L2_L1 (read_data_L2_L1)
`ifdef L1D_PERF_CNT_EN
        ,
        .hit_cnt         (hit_cnt),
        .miss_cnt        (miss_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: what the cache should hold, set by set.
    bit          m_valid [32];
    logic [20:0] m_tag   [32];
    logic [31:0] m_data  [32][16];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_addr(input logic [31:0] a);
        tag_C_L1   = a[31:11];
        index_C_L1 = a[10:6];
        offset     = a[5:0];
    endtask

    task automatic model_reset();
        for (int s = 0; s < 32; s++) m_valid[s] = 1'b0;
    endtask

    // One core read of address a. On a model miss the bench plays L2: 16
    // beats (base+i or random), a gap of gap_len idle cycles before beat
    // gap_at, random short gaps elsewhere when random_gaps is set, and an
    // optional withdrawal of the request during the refill.
    task automatic access(input logic [31:0] a, input bit use_base, input logic [31:0] base,
                          input int gap_at, input int gap_len, input bit random_gaps,
                          input bit withdraw, output logic [31:0] rd);
        int          idx;
        int          w;
        int          gap;
        bit          exp_hit;
        logic [31:0] beat;
        logic [31:0] line_addr;
        idx       = int'(a[10:6]);
        w         = int'(a[5:2]);
        line_addr = {a[31:6], 6'b0};
        exp_hit   = m_valid[idx] && (m_tag[idx] == a[31:11]);
        set_addr(a);
        read_C_L1D      = 1'b1;
        ready_L2_L1     = exp_hit ? 1'($urandom_range(0, 1)) : 1'b0;
        read_data_L2_L1 = $urandom;
        @(negedge clk);
        check("stall_on_request", {31'd0, stall_L1D}, {31'd0, !exp_hit});
        if (exp_hit) begin
            check("hit_data", read_data_L1D_C, m_data[idx][w]);
            check("hit_no_l2_req", {31'd0, read_L1_L2}, 32'd0);
            rd = read_data_L1D_C;
            step();
            read_C_L1D  = 1'b0;
            ready_L2_L1 = 1'b0;
            return;
        end
        step();
        m_valid[idx] = 1'b0;
        for (int i = 0; i < 16; i++) begin
            gap = (i == gap_at) ? gap_len : (random_gaps ? $urandom_range(0, 2) : 0);
            for (int g = 0; g < gap; g++) begin
                ready_L2_L1     = 1'b0;
                read_data_L2_L1 = $urandom;
                @(negedge clk);
                check("l2_req_held_in_gap", {31'd0, read_L1_L2}, 32'd1);
                check("stall_in_gap", {31'd0, stall_L1D}, 32'd1);
                step();
            end
            beat = use_base ? (base + 32'(i)) : $urandom;
            m_data[idx][i]  = beat;
            ready_L2_L1     = 1'b1;
            read_data_L2_L1 = beat;
            if (withdraw && i == 4) read_C_L1D = 1'b0;
            @(negedge clk);
            check("l2_req", {31'd0, read_L1_L2}, 32'd1);
            check("l2_addr", address_L1_L2, line_addr);
            check("stall_refill", {31'd0, stall_L1D}, 32'd1);
            step();
        end
        ready_L2_L1     = 1'b0;
        read_data_L2_L1 = $urandom;
        @(negedge clk);
        check("l2_req_dropped", {31'd0, read_L1_L2}, 32'd0);
        check("stall_update", {31'd0, stall_L1D}, 32'd1);
        m_valid[idx] = 1'b1;
        m_tag[idx]   = a[31:11];
        step();
        @(negedge clk);
        check("replay_stall", {31'd0, stall_L1D}, 32'd0);
        check("replay_data", read_data_L1D_C, withdraw ? 32'd0 : m_data[idx][w]);
        rd = read_data_L1D_C;
        step();
        read_C_L1D = 1'b0;
    endtask

    // A cycle with no request; stray L2 beats must be ignored.
    task automatic idle_cycle();
        read_C_L1D      = 1'b0;
        ready_L2_L1     = 1'($urandom_range(0, 1));
        read_data_L2_L1 = $urandom;
        set_addr($urandom);
        @(negedge clk);
        check("idle_stall", {31'd0, stall_L1D}, 32'd0);
        check("idle_data", read_data_L1D_C, 32'd0);
        check("idle_l2_req", {31'd0, read_L1_L2}, 32'd0);
        step();
        ready_L2_L1 = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic [31:0] tags [3];
        logic [31:0] a;
        tags[0] = 32'h20000;
        tags[1] = 32'h20001;
        tags[2] = 32'h3ABCD;

        nrst            = 1'b1;
        read_C_L1D      = 1'b0;
        ready_L2_L1     = 1'b0;
        read_data_L2_L1 = '0;
        set_addr(32'h0);
        model_reset();
        repeat (3) step();
        @(negedge clk);
        check("reset_stall", {31'd0, stall_L1D}, 32'd0);
        check("reset_l2_req", {31'd0, read_L1_L2}, 32'd0);
        check("reset_l2_addr", address_L1_L2, 32'd0);
        check("reset_data", read_data_L1D_C, 32'd0);
        step();
        nrst = 1'b0;
        idle_cycle();

        // Scenario 1: cold miss, ordered beats, word 2 returned.
        access(32'h1000_0048, 1'b1, 32'hA0, -1, 0, 1'b0, 1'b0, rd);
        check("s1_data", rd, 32'h0000_00A2);
        // Scenario 2: hit on the same line, last word.
        access(32'h1000_007C, 1'b1, 32'h0, -1, 0, 1'b0, 1'b0, rd);
        check("s2_data", rd, 32'h0000_00AF);
`ifdef L1D_PERF_CNT_EN
        @(negedge clk);
        check("perf_miss_cnt", miss_cnt, 32'd1);
        check("perf_hit_cnt", hit_cnt, 32'd1);
        step();
`endif
        // Scenario 3: conflict miss in set 1, then the evicted line misses again.
        access(32'h1000_0848, 1'b1, 32'hB0, -1, 0, 1'b0, 1'b0, rd);
        check("s3_data", rd, 32'h0000_00B2);
        access(32'h1000_0048, 1'b1, 32'hA0, -1, 0, 1'b0, 1'b0, rd);
        check("s3_reread", rd, 32'h0000_00A2);

        // Scenario 4: five-cycle L2 gap between beats 7 and 8.
        access(32'h2345_6784, 1'b1, 32'hC0, 8, 5, 1'b0, 1'b0, rd);
        check("s4_data", rd, 32'h0000_00C1);

        // Scenario 5: reset after beat 9 aborts the refill.
        a = 32'h0ABC_D1C8;
        set_addr(a);
        read_C_L1D = 1'b1;
        @(negedge clk);
        check("s5_miss_stall", {31'd0, stall_L1D}, 32'd1);
        step();
        for (int i = 0; i < 10; i++) begin
            ready_L2_L1     = 1'b1;
            read_data_L2_L1 = 32'hD0 + 32'(i);
            step();
        end
        ready_L2_L1 = 1'b0;
        nrst        = 1'b1;
        step();
        model_reset();
        @(negedge clk);
        check("s5_l2_req_after_reset", {31'd0, read_L1_L2}, 32'd0);
        check("s5_stall_after_reset", {31'd0, stall_L1D}, 32'd0);
        read_C_L1D = 1'b0;
        step();
        nrst = 1'b0;
        idle_cycle();
        access(a, 1'b1, 32'hE0, -1, 0, 1'b0, 1'b0, rd);
        check("s5_refill_data", rd, 32'h0000_00E2);
        // Earlier lines were invalidated by the reset.
        access(32'h1000_0848, 1'b1, 32'hB0, -1, 0, 1'b0, 1'b0, rd);
        check("s5_post_reset_miss", rd, 32'h0000_00B2);

        // Withdrawn request: refill still completes and the line is usable.
        access(32'h0000_0100, 1'b0, 32'h0, -1, 0, 1'b1, 1'b1, rd);
        access(32'h0000_0104, 1'b0, 32'h0, -1, 0, 1'b0, 1'b0, rd);

        // Randomized traffic over a small tag/index pool to force hits and conflicts.
        for (int n = 0; n < 60; n++) begin
            a = {tags[$urandom_range(0, 2)][20:0], 5'($urandom_range(0, 3)), 6'($urandom_range(0, 63))};
            access(a, 1'b0, 32'h0, int'($urandom_range(0, 20)), int'($urandom_range(0, 4)),
                   1'b1, ($urandom_range(0, 7) == 0), rd);
            if ($urandom_range(0, 2) == 0) idle_cycle();
        end

`ifdef L1D_PERF_CNT_EN
        // Saturation: a pinned miss counter must not wrap on another miss.
        @(negedge clk);
        force dut.miss_cnt_q = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        release dut.miss_cnt_q;
        access(32'h7FFF_F800, 1'b0, 32'h0, -1, 0, 1'b0, 1'b0, rd);
        @(negedge clk);
        check("perf_miss_saturate", miss_cnt, 32'hFFFF_FFFF);
        step();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
